// File: rtl/usb_rx_line_decoder.sv
// usb_rx_line_decoder
//   Receive front end for the serial link. Samples the line pair once per
//   clock, detects SYNC, NRZI-decodes, strips stuffed bits and detects EOP.
//   Every output is registered, so each one lags its sampled symbol by 1 cycle.
// Ports
//   clk      : system clock, all state updates on posedge
//   rst_L    : asynchronous active-low reset
//   dp, dm   : line pair, already synchronised to clk
//   inb      : decoded, unstuffed bit; valid when recving=1 and pause=0
//   recving  : high across the packet body (first PID bit to last data bit)
//   pause    : one-cycle marker for a stripped stuff bit (only while recving)
//   rx_error : one-cycle pulse on a line-level error
module usb_rx_line_decoder (
  input  logic clk,
  input  logic rst_L,
  input  logic dp,
  input  logic dm,
  output logic inb,
  output logic recving,
  output logic pause,
  output logic rx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_RECV,
    S_EOP,
    S_WAIT_J
  } state_t;

  state_t      state_q, state_d;
  logic        prev_q, prev_d;      // last J/K seen; 1 = J
  logic [2:0]  zcnt_q, zcnt_d;      // SYNC zeros seen
  logic [2:0]  ones_q, ones_d;      // consecutive decoded ones (stuffing)
  logic [1:0]  se0_q, se0_d;        // SE0 symbols in EOP, saturating
  logic        inb_q, inb_d;
  logic        recving_q, recving_d;
  logic        pause_q, pause_d;
  logic        err_q, err_d;

  logic is_j, is_k, is_se0, is_jk, bit_dec;

  always_comb begin
    is_j    = dp & ~dm;
    is_k    = ~dp & dm;
    is_se0  = ~dp & ~dm;
    is_jk   = is_j | is_k;
    // NRZI: no transition decodes as 1. Only meaningful when is_jk.
    bit_dec = ~(dp ^ prev_q);
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = is_jk ? dp : prev_q;
    zcnt_d    = zcnt_q;
    ones_d    = ones_q;
    se0_d     = se0_q;
    inb_d     = 1'b0;
    recving_d = 1'b0;
    pause_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_k && prev_q) begin
          state_d = S_SYNC;
          zcnt_d  = 3'd1;
        end
      end

      S_SYNC: begin
        if (is_jk) begin
          if (!bit_dec) begin
            if (zcnt_q == 3'd7) state_d = S_IDLE;
            else                zcnt_d  = zcnt_q + 3'd1;
          end else if (zcnt_q == 3'd7) begin
            // The closing SYNC 1 already counts toward the stuffing run.
            state_d = S_RECV;
            ones_d  = 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RECV: begin
        if (is_jk) begin
          if (ones_q != 3'd6) begin
            inb_d     = bit_dec;
            recving_d = 1'b1;
            ones_d    = bit_dec ? ones_q + 3'd1 : 3'd0;
          end else if (!bit_dec) begin
            pause_d   = 1'b1;
            recving_d = 1'b1;
            ones_d    = 3'd0;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_J;
          end
        end else if (is_se0) begin
          se0_d   = 2'd1;
          state_d = S_EOP;
        end else begin
          err_d   = 1'b1;
          state_d = S_WAIT_J;
        end
      end

      S_EOP: begin
        if (is_se0) begin
          if (se0_q != 2'd3) se0_d = se0_q + 2'd1;
        end else if (is_j) begin
          err_d   = (se0_q < 2'd2);
          prev_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = S_WAIT_J;
        end
      end

      S_WAIT_J: begin
        if (is_j) begin
          prev_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= S_IDLE;
      prev_q    <= 1'b1;
      zcnt_q    <= '0;
      ones_q    <= '0;
      se0_q     <= '0;
      inb_q     <= 1'b0;
      recving_q <= 1'b0;
      pause_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      zcnt_q    <= zcnt_d;
      ones_q    <= ones_d;
      se0_q     <= se0_d;
      inb_q     <= inb_d;
      recving_q <= recving_d;
      pause_q   <= pause_d;
      err_q     <= err_d;
    end
  end

  assign inb      = inb_q;
  assign recving  = recving_q;
  assign pause    = pause_q;
  assign rx_error = err_q;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
module tb_usb_rx_line_decoder;

  logic clk = 1'b0;
  logic rst_L = 1'b1;
  logic dp = 1'b1;
  logic dm = 1'b0;
  logic inb, recving, pause, rx_error;

  usb_rx_line_decoder dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .dp       (dp),
    .dm       (dm),
    .inb      (inb),
    .recving  (recving),
    .pause    (pause),
    .rx_error (rx_error)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_SE1 = 2'b11;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic line_j   = 1'b1;   // bench view of the last J/K driven
  int   rcv_cnt, pause_cnt, err_cnt, inv_cnt;
  logic data_q[$];

  task automatic clear_stats();
    rcv_cnt = 0; pause_cnt = 0; err_cnt = 0; inv_cnt = 0;
    data_q.delete();
  endtask

  // Drive one symbol, let it be sampled, then observe the registered outputs.
  task automatic step(input logic [1:0] s);
    {dp, dm} = s;
    if (s == SYM_J) line_j = 1'b1;
    if (s == SYM_K) line_j = 1'b0;
    @(posedge clk);
    #1;
    if (recving) rcv_cnt++;
    if (pause) pause_cnt++;
    if (rx_error) err_cnt++;
    if (pause && !recving) inv_cnt++;
    if (recving && !pause) data_q.push_back(inb);
  endtask

  task automatic send_bit(input logic b);
    if (!b) line_j = ~line_j;
    step(line_j ? SYM_J : SYM_K);
  endtask

  task automatic send_sync();
    step(SYM_K); step(SYM_J); step(SYM_K); step(SYM_J);
    step(SYM_K); step(SYM_J); step(SYM_K); step(SYM_K);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  function automatic logic [15:0] data_vec();
    logic [15:0] r = '0;
    foreach (data_q[i]) r = {r[14:0], data_q[i]};
    return r;
  endfunction

  task automatic test_reset();
    rst_L = 1'b0;
    #1;
    n_checks++;
    if ({inb, recving, pause, rx_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000", {inb, recving, pause, rx_error});
    end
    step(SYM_J); step(SYM_J);
    rst_L = 1'b1;
    clear_stats();
    step(SYM_J); step(SYM_J);
    n_checks++;
    if (rcv_cnt + err_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: recving/err cycles %0d required 0", rcv_cnt + err_cnt);
    end
  endtask

  task automatic test_ack();
    logic [15:0] got;
    clear_stats();
    send_sync();
    n_checks++;
    if (recving !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_sync_end_recving: got %b required 0", recving);
    end
    send_bits(16'b01001011, 8);
    n_checks++;
    if (recving !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_last_bit_recving: got %b required 1", recving);
    end
    step(SYM_SE0);
    n_checks++;
    if (recving !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_se0_recving: got %b required 0", recving);
    end
    step(SYM_SE0); step(SYM_J); step(SYM_J);
    got = data_vec();
    n_checks++;
    if (rcv_cnt !== 8) begin
      n_fail++;
      $display("FAIL ack_recv_cycles: got %0d required 8", rcv_cnt);
    end
    n_checks++;
    if (data_q.size() !== 8 || got[7:0] !== 8'b01001011) begin
      n_fail++;
      $display("FAIL ack_data: got %0d bits %b required 8 bits 01001011", data_q.size(), got[7:0]);
    end
    n_checks++;
    if (pause_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL ack_pause_err: got pause %0d err %0d required 0 0", pause_cnt, err_cnt);
    end
  endtask

  task automatic test_stuffing();
    clear_stats();
    send_sync();
    send_bits(16'b11111, 5);
    send_bit(1'b0);
    n_checks++;
    if ({recving, pause} !== 2'b11) begin
      n_fail++;
      $display("FAIL stuff_pause_align: got recving,pause=%b required 11", {recving, pause});
    end
    send_bits(16'b111, 3);
    step(SYM_SE0); step(SYM_SE0); step(SYM_SE0); step(SYM_SE0); step(SYM_J);
    n_checks++;
    if (pause_cnt !== 1 || rcv_cnt !== 9) begin
      n_fail++;
      $display("FAIL stuff_counts: got pause %0d recv %0d required 1 9", pause_cnt, rcv_cnt);
    end
    n_checks++;
    if (data_q.size() !== 8 || data_vec() !== 16'h00FF) begin
      n_fail++;
      $display("FAIL stuff_data: got %0d bits %h required 8 bits 00ff", data_q.size(), data_vec());
    end
    n_checks++;
    if (err_cnt !== 0 || inv_cnt !== 0) begin
      n_fail++;
      $display("FAIL stuff_long_eop_err: got err %0d inv %0d required 0 0", err_cnt, inv_cnt);
    end
    step(SYM_J);
  endtask

  task automatic test_stuff_error();
    clear_stats();
    send_sync();
    send_bits(16'b11111, 5);
    send_bit(1'b1);
    n_checks++;
    if ({rx_error, recving, pause} !== 3'b100) begin
      n_fail++;
      $display("FAIL stuff_err_pulse: got err,recv,pause=%b required 100", {rx_error, recving, pause});
    end
    step(SYM_K); step(SYM_K);
    send_sync();
    step(SYM_J); step(SYM_J);
    n_checks++;
    if (err_cnt !== 1 || rcv_cnt !== 5) begin
      n_fail++;
      $display("FAIL stuff_err_waitj: got err %0d recv %0d required 1 5", err_cnt, rcv_cnt);
    end
    clear_stats();
    send_sync();
    send_bits(16'b10100101, 8);
    step(SYM_SE0); step(SYM_SE0); step(SYM_J); step(SYM_J);
    n_checks++;
    if (rcv_cnt !== 8 || data_vec() !== 16'h00A5 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL stuff_err_recover: got recv %0d data %h err %0d required 8 00a5 0", rcv_cnt, data_vec(), err_cnt);
    end
  endtask

  task automatic test_bad_sync();
    clear_stats();
    step(SYM_K); step(SYM_J); step(SYM_K); step(SYM_J); step(SYM_K); step(SYM_K);
    send_bits(16'b0110, 4);
    step(SYM_J); step(SYM_J);
    n_checks++;
    if (rcv_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL bad_sync: got recv %0d err %0d required 0 0", rcv_cnt, err_cnt);
    end
    clear_stats();
    send_sync();
    send_bits(16'b0110, 4);
    step(SYM_SE0); step(SYM_SE0); step(SYM_J);
    n_checks++;
    if (rcv_cnt !== 4 || data_vec() !== 16'h0006) begin
      n_fail++;
      $display("FAIL bad_sync_recover: got recv %0d data %h required 4 0006", rcv_cnt, data_vec());
    end
  endtask

  task automatic test_bad_eop();
    clear_stats();
    send_sync();
    send_bits(16'b10, 2);
    step(SYM_SE0);
    step(SYM_J);
    n_checks++;
    if (rx_error !== 1'b1) begin
      n_fail++;
      $display("FAIL short_eop_err: got %b required 1", rx_error);
    end
    step(SYM_J);
    n_checks++;
    if (rx_error !== 1'b0 || err_cnt !== 1) begin
      n_fail++;
      $display("FAIL short_eop_pulse: got now %b total %0d required 0 1", rx_error, err_cnt);
    end
    clear_stats();
    send_sync();
    send_bits(16'b01, 2);
    step(SYM_SE0); step(SYM_SE0);
    step(SYM_K);
    n_checks++;
    if (rx_error !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_eop_k_err: got %b required 1", rx_error);
    end
    step(SYM_J); step(SYM_J);
    clear_stats();
    send_sync();
    send_bits(16'b11, 2);
    step(SYM_SE1);
    n_checks++;
    if ({rx_error, recving} !== 2'b10 || rcv_cnt !== 2) begin
      n_fail++;
      $display("FAIL se1_in_recv: got err,recv=%b cycles %0d required 10 2", {rx_error, recving}, rcv_cnt);
    end
    step(SYM_J); step(SYM_J);
  endtask

  task automatic test_reset_mid_packet();
    clear_stats();
    send_sync();
    send_bits(16'b010, 3);
    send_bit(1'b0);
    n_checks++;
    if (recving !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got recving %b required 1", recving);
    end
    #2 rst_L = 1'b0;
    #1;
    n_checks++;
    if ({inb, recving, pause, rx_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_async: got %b required 0000", {inb, recving, pause, rx_error});
    end
    @(negedge clk);
    rst_L = 1'b1;
    clear_stats();
    send_bits(16'b1011, 4);
    step(SYM_SE0); step(SYM_SE0); step(SYM_J); step(SYM_J);
    n_checks++;
    if (rcv_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL midrst_ignore: got recv %0d err %0d required 0 0", rcv_cnt, err_cnt);
    end
    clear_stats();
    send_sync();
    send_bits(16'b00111100, 8);
    step(SYM_SE0); step(SYM_SE0); step(SYM_J);
    n_checks++;
    if (rcv_cnt !== 8 || data_vec() !== 16'h003C || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL midrst_fresh: got recv %0d data %h err %0d required 8 003c 0", rcv_cnt, data_vec(), err_cnt);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ack();
    test_stuffing();
    test_stuff_error();
    test_bad_sync();
    test_bad_eop();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_line_decoder.md
# usb_rx_line_decoder

Receive front end for the serial link. It samples the differential line pair (dp, dm) once per clock, detects SYNC, NRZI-decodes, strips stuffed bits and detects EOP. It drives the recving / pause / inb bit stream that `bitstream_decoder` consumes directly. One line symbol is presented per clock; no clock recovery or oversampling is performed here.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge
- rst_L  in  1  asynchronous, active-low reset
- dp  in  1  line D+ (already synchronised to clk)
- dm  in  1  line D-
- inb  out  1  decoded, unstuffed data bit; meaningful only when recving=1 and pause=0
- recving  out  1  high for the whole packet body (first PID bit through last bit before EOP)
- pause  out  1  high for one cycle per stripped stuff bit; inb is invalid that cycle
- rx_error  out  1  one-cycle pulse on a line-level error

## Operation
- Line symbols: J = dp1/dm0; K = dp0/dm1; SE0 = 0/0; SE1 = 1/1 (illegal).
- NRZI: decoded bit = 1 if the current J/K equals prev_line, 0 if it differs.
- prev_line register: updates on every J/K sample. It is not updated on SE0/SE1. Its reset value is J.
- States:
  - IDLE -> SYNC when the sample is K and prev_line=J. This first K is zero #1, so zcnt=1.
  - SYNC, decoded 0: zcnt++. If zcnt would exceed 7 -> IDLE.
  - SYNC, decoded 1: if zcnt=7 -> RECV with ones_run=1, because the trailing SYNC 1 counts toward stuffing. Otherwise -> IDLE.
  - SYNC, SE0 or SE1 -> IDLE. No rx_error is raised in SYNC.
  - RECV, J/K with ones_run<6: output the bit. inb=bit, recving=1, pause=0. ones_run = bit ? ones_run+1 : 0.
  - RECV, J/K with ones_run=6: this is a stuff bit. If decoded 0: pause=1, recving=1, ones_run=0. If decoded 1: rx_error pulse, recving=0 -> WAIT_J.
  - RECV, SE0: recving=0, se0cnt=1 -> EOP.
  - RECV, SE1: rx_error, recving=0 -> WAIT_J.
  - EOP, SE0: se0cnt++, saturating at 3.
  - EOP, J: -> IDLE. Raise rx_error if se0cnt<2.
  - EOP, K or SE1: rx_error -> WAIT_J.
  - WAIT_J: stay until the sample is J, then -> IDLE.
- Invariant: recving=0 implies pause=0. This lets the downstream stage see end-of-packet on any non-paused cycle.
- Invariant: pause=1 only in RECV.
- prev_line is set to J on entry to IDLE from EOP or WAIT_J.
- No packet-length limit. Length and PID checks belong downstream.

## Timing
- All outputs are registered. The symbol sampled at edge N determines inb/recving/pause/rx_error for the cycle after edge N, so latency is 1 cycle. rx_error is high for exactly that one cycle.
- First PID bit sampled at edge N: recving rises after edge N and stays high contiguously until the first SE0 is sampled.
- Last data bit at edge N, SE0 at edge N+1: recving=0 after edge N+1.
- Minimum line gap is whatever the downstream needs. This block can accept a new SYNC on the cycle after returning to IDLE.
- Reset (async, any state): inb=0, recving=0, pause=0, rx_error=0, state=IDLE, prev_line=J, all counters 0. Outputs go low immediately on assertion, not at the next edge.
- Reset mid-packet: no rx_error is generated. After release, a fresh SYNC is required.

## Test plan
- ACK packet: J idle, SYNC KJKJKJKK, then line symbols encoding decoded bits 0,1,0,0,1,0,1,1, then SE0, SE0, J -> recving high exactly 8 cycles; inb = 0,1,0,0,1,0,1,1; pause never high; rx_error 0.
- Stuffing: SYNC, then decoded data 1,1,1,1,1, stuff 0, then 1,1,1, then EOP -> pause high exactly one cycle, aligned to the stuff bit; recving high 9 cycles; the eight non-paused inb values are all 1.
- Stuff error: SYNC, then decoded 1,1,1,1,1, then 1 -> rx_error pulses once, recving drops with pause=0; block ignores K/J until J; the next valid packet decodes normally.
- Bad SYNC: KJKJKK followed by J idle -> recving stays 0, rx_error stays 0, block back in IDLE; the next correct SYNC is accepted.
- Short / bad EOP: packet ending SE0, J -> rx_error one cycle, return to IDLE. Packet ending SE0, SE0, K -> rx_error, WAIT_J.
- Reset mid-packet: assert rst_L low during the 4th data bit -> all outputs 0 asynchronously; after release, the remaining line symbols are ignored until a fresh SYNC.
